mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, data width per requester.
REQ-002 SHALL have parameter TIMEOUT, default 16, idle-cycle limit for grant watchdog (used only under REQ-030).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  4  per-requester word valid.
REQ-006 req_data  input  4*W  requester i data at bits [i*W +: W].
REQ-007 req_last  input  4  per-requester last word of packet.
REQ-008 req_ready  output  4  per-requester accept; one-hot or zero.
REQ-009 out_valid  output  1  muxed word valid.
REQ-010 out_data  output  W  muxed word.
REQ-011 out_last  output  1  muxed last flag.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_sel  output  2  index of current grant; drives the 4:1 select.
REQ-014 busy  output  1  high while a grant is held.

Function
REQ-015 SHALL implement FSM states IDLE and GRANT.
REQ-016 IDLE: if any req_valid is high, SHALL register a grant g (the first requester with valid high searching ptr, ptr+1, ... mod 4) and enter GRANT next cycle; arbitration latency exactly 1 cycle.
REQ-017 IDLE: out_valid, req_ready and busy SHALL be 0; no data transfers.
REQ-018 GRANT: out_valid=req_valid[g], out_data=req_data[g], out_last=req_last[g], req_ready[g]=out_ready, all other req_ready bits 0 (combinational pass-through, zero added latency).
REQ-019 Transfer SHALL occur on a cycle with out_valid and out_ready both high.
REQ-020 Grant SHALL be held across all transfers until a transfer with out_last=1; then the FSM returns to IDLE and ptr=(g+1) mod 4 (wrap 3->0).
REQ-021 Valid drops mid-packet SHALL NOT release the grant (except REQ-030).
REQ-022 out_sel SHALL equal g in GRANT and hold its last value in IDLE.
REQ-023 busy SHALL be 1 exactly in GRANT.
REQ-024 New requests arriving during GRANT SHALL be ignored until IDLE; no preemption.
REQ-025 A requester with a single-word packet (last on first word) SHALL be served in 2 cycles (1 arbitrate + 1 transfer) when out_ready=1.

Reset
REQ-026 rst high at any clock edge SHALL force state=IDLE, ptr=0, g=0, out_sel=0, timeout counter=0, timeout_pulse=0.
REQ-027 Reset mid-packet SHALL abandon the packet; out_valid, req_ready and busy SHALL be 0 in the cycle after the reset edge.
REQ-028 rst SHALL take priority over all other events in the same cycle.

Configuration
REQ-029 Without ARB_TIMEOUT_EN: no watchdog logic and no timeout_pulse port; behaviour per REQ-015..REQ-025.
REQ-030 With ARB_TIMEOUT_EN: adds output timeout_pulse (1 bit); in GRANT, a counter increments each cycle req_valid[g]=0 and clears on any cycle req_valid[g]=1; on reaching TIMEOUT, the FSM SHALL return to IDLE, ptr=(g+1) mod 4, and timeout_pulse SHALL be high for exactly 1 cycle.

Structure
REQ-031 Shared package mux_arb_pkg SHALL hold N_REQ=4, SEL_W=2 and the FSM state enum (IDLE, GRANT).
REQ-032 Data selection SHALL use one sub-module mux4_w: W-wide 4:1 case-based mux, select out_sel.
REQ-033 The round-robin pick SHALL be combinational from req_valid and ptr, registered into g.

Verification
REQ-034 Reset then req_valid=4'b0101, all last=1, out_ready=1 -> grants 0 then 2, out_sel 0,2; ptr ends 3.
REQ-035 All four valid continuously, last=1 -> grant order 0,1,2,3,0; each grant 2 cycles.
REQ-036 Requester 1 sends 3-word packet (0xA1,0xA2,0xA3, last on 0xA3) with out_ready low on word 2 for 2 cycles -> out_data sequence A1,A2,A3; req_ready[1] tracks out_ready; grant held throughout.
REQ-037 rst asserted in the middle of a 4-word packet -> next cycle busy=0, out_valid=0, ptr=0; subsequent request from 2 granted normally.
REQ-038 With ARB_TIMEOUT_EN, TIMEOUT=4: grant 3, drop req_valid[3] for 4 cycles -> timeout_pulse for 1 cycle, IDLE, next pending requester 0 granted.
REQ-039 Requester 2 raises valid while 0 holds a grant -> 2 not served until 0's last transfer completes.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the 4-input round-robin packet arbiter/mux.
//   N_REQ   : number of requesters (4)
//   SEL_W   : width of a requester index (2)
//   state_e : arbiter FSM states (IDLE, GRANT)
//   pick_t  : result of a round-robin search (found flag + winning index)
//   rr_pick : combinational round-robin search starting at a pointer
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    // First requester with valid high, searching ptr, ptr+1, ... (mod 4).
    // The loop runs from the largest offset down so the smallest offset
    // from ptr is the one left standing.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid, input sel_t ptr);
        pick_t p;
        sel_t  cand;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + sel_t'(i);
            if (valid[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundles the requester-side and downstream-side handshake of the arbiter.
//   req_valid/req_data/req_last : 4 requesters, data of requester i at [i*W +: W]
//   req_ready                   : per-requester accept (one-hot or zero)
//   out_valid/out_data/out_last : muxed stream towards downstream
//   out_ready                   : downstream accept
//   out_sel                     : index of current grant
//   busy                        : high while a grant is held
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters + downstream sink)
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int W = 8
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic               out_last;
    logic               out_ready;
    logic [SEL_W-1:0]   out_sel;
    logic               busy;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_sel, busy
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_sel, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// ---------------------------------------------------------------------------
// mux4_w
// W-wide 4:1 data multiplexer.
//   sel_i  : requester index
//   data_i : four packed W-bit lanes, lane i at [i*W +: W]
//   data_o : selected lane
// ---------------------------------------------------------------------------
module mux4_w
    import mux_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  sel_t               sel_i,
    input  logic [N_REQ*W-1:0] data_i,
    output logic [W-1:0]       data_o
);
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via default) so no latch is inferred.
        data_o = data_i[0 +: W];
        case (sel_i)
            2'd0:    data_o = data_i[0*W +: W];
            2'd1:    data_o = data_i[1*W +: W];
            2'd2:    data_o = data_i[2*W +: W];
            2'd3:    data_o = data_i[3*W +: W];
            default: data_o = data_i[0 +: W];
        endcase
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin packet arbiter in front of a 4:1 data mux. In IDLE it picks the
// next valid requester starting from a rotating pointer (1 cycle latency);
// in GRANT it passes the granted requester's stream straight through until a
// transfer carrying last, then moves the pointer past the served requester.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : requester/downstream handshake, out_sel, busy
//   timeout_pulse  : 1-cycle pulse when the grant watchdog fires
//                    (only present when ARB_TIMEOUT_EN is defined)
// Optional feature macro: ARB_TIMEOUT_EN -- releases a grant whose requester
// has been idle for TIMEOUT consecutive cycles.
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    mux4_rr_arbiter_if.slave    bus
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                timeout_pulse
`endif
);
    state_e state_q;
    sel_t   ptr_q;
    sel_t   g_q;
    logic   busy_q;

    pick_t  pick;
    logic   in_grant;
    logic   g_valid;
    logic   g_last;
    logic   pkt_done;

    always_comb pick = rr_pick(bus.req_valid, ptr_q);

    assign in_grant = (state_q == GRANT);
    assign g_valid  = bus.req_valid[g_q];
    assign g_last   = bus.req_last[g_q];
    // Last word of the packet accepted downstream.
    assign pkt_done = in_grant & g_valid & bus.out_ready & g_last;

    // Zero-latency pass-through of the granted requester.
    assign bus.out_valid = in_grant & g_valid;
    assign bus.out_last  = in_grant & g_last;
    assign bus.out_sel   = g_q;
    assign bus.busy      = busy_q;

    always_comb begin
        bus.req_ready = '0;
        if (in_grant) bus.req_ready[g_q] = bus.out_ready;
    end

    mux4_w #(.W(W)) u_mux (
        .sel_i  (g_q),
        .data_i (bus.req_data),
        .data_o (bus.out_data)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             timeout_pulse_q;
    logic             tmo_hit;

    // The cycle that would bring the idle count up to TIMEOUT.
    assign tmo_hit       = in_grant & ~g_valid & (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout_pulse = timeout_pulse_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_pulse_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick.found) begin
                        g_q     <= pick.idx;
                        state_q <= GRANT;
                        busy_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (pkt_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= g_q + sel_t'(1);
                    end
`ifdef ARB_TIMEOUT_EN
                    if (g_valid) begin
                        tmo_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        state_q         <= IDLE;
                        busy_q          <= 1'b0;
                        ptr_q           <= g_q + sel_t'(1);
                        tmo_cnt_q       <= '0;
                        timeout_pulse_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed bench for mux4_rr_arbiter: reset state, round-robin order,
// multi-word packets with backpressure, reset mid-packet, no preemption and,
// when ARB_TIMEOUT_EN is defined, the grant watchdog (TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// a further time unit later.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef ARB_TIMEOUT_EN
    logic timeout_pulse;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.W(W)) bus ();

    mux4_rr_arbiter #(.W(W), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_pulse (timeout_pulse)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] v);
        bus.req_data[i*W +: W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Checks of the externally visible GRANT-phase outputs.
    task automatic check_grant(input string tag, input logic [1:0] g, input logic [3:0] rdy);
        check({tag, ".busy"},  32'(bus.busy),      32'd1);
        check({tag, ".sel"},   32'(bus.out_sel),   32'(g));
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    endtask

    task automatic check_idle(input string tag, input logic [1:0] sel);
        check({tag, ".busy"},   32'(bus.busy),      32'd0);
        check({tag, ".ovalid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".ready"},  32'(bus.req_ready), 32'd0);
        check({tag, ".sel"},    32'(bus.out_sel),   32'(sel));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_lane(i, W'(8'h10 * (i + 1)));

        // ---- reset state ----
        step();
        step();
        rst = 1'b0;
        settle();
        check_idle("rst", 2'd0);
        check("rst.ptr", 32'(dut.ptr_q), 32'd0);

        // ---- valid 0101, single-word packets: grants 0 then 2, ptr ends 3 ----
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b1111;
        bus.out_ready = 1'b1;
        settle();
        check_idle("p34.arb0", 2'd0);
        step();
        check_grant("p34.g0", 2'd0, 4'b0001);
        check("p34.g0.data",  32'(bus.out_data),  32'h10);
        check("p34.g0.valid", 32'(bus.out_valid), 32'd1);
        check("p34.g0.last",  32'(bus.out_last),  32'd1);
        step();
        check_idle("p34.arb1", 2'd0);
        check("p34.ptr1", 32'(dut.ptr_q), 32'd1);
        step();
        check_grant("p34.g2", 2'd2, 4'b0100);
        check("p34.g2.data", 32'(bus.out_data), 32'h30);
        step();
        bus.req_valid = 4'b0000;
        settle();
        check_idle("p34.end", 2'd2);
        check("p34.ptr3", 32'(dut.ptr_q), 32'd3);

        // ---- all four valid, last=1: order 0,1,2,3,0, 2 cycles each ----
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("p35.idle.busy", 32'(bus.busy), 32'd0);
            step();
            check_grant("p35.grant", 2'(k % 4), 4'(1 << (k % 4)));
            check("p35.data", 32'(bus.out_data), 32'(8'h10 * ((k % 4) + 1)));
            step();
        end
        bus.req_valid = 4'b0000;

        // ---- no preemption: 2 raises valid while 0 holds a grant ----
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0000;
        step();
        check_grant("p39.g0", 2'd0, 4'b0001);
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b0100;
        step();
        check_grant("p39.hold1", 2'd0, 4'b0001);
        step();
        check_grant("p39.hold2", 2'd0, 4'b0001);
        bus.req_last = 4'b0101;
        settle();
        check("p39.last", 32'(bus.out_last), 32'd1);
        step();
        bus.req_valid = 4'b0100;
        settle();
        check_idle("p39.rel", 2'd0);
        step();
        check_grant("p39.g2", 2'd2, 4'b0100);
        step();
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;

        // ---- 3-word packet from 1 with 2 cycles of backpressure ----
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0000;
        set_lane(1, 8'hA1);
        step();
        check_grant("p36.w1", 2'd1, 4'b0010);
        check("p36.w1.data", 32'(bus.out_data), 32'hA1);
        step();
        set_lane(1, 8'hA2);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            check_grant("p36.stall", 2'd1, 4'b0000);
            check("p36.stall.data", 32'(bus.out_data), 32'hA2);
            step();
        end
        bus.out_ready = 1'b1;
        settle();
        check_grant("p36.w2", 2'd1, 4'b0010);
        check("p36.w2.data", 32'(bus.out_data), 32'hA2);
        step();
        set_lane(1, 8'hA3);
        bus.req_last = 4'b0010;
        settle();
        check_grant("p36.w3", 2'd1, 4'b0010);
        check("p36.w3.data", 32'(bus.out_data), 32'hA3);
        check("p36.w3.last", 32'(bus.out_last), 32'd1);
        step();
        bus.req_valid = 4'b0000;
        settle();
        check_idle("p36.done", 2'd1);
        check("p36.ptr", 32'(dut.ptr_q), 32'd2);

        // ---- reset in the middle of a 4-word packet from 3 ----
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b0000;
        step();
        check_grant("p37.g3", 2'd3, 4'b1000);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_valid = 4'b0100;
        settle();
        check_idle("p37.after", 2'd0);
        check("p37.ptr", 32'(dut.ptr_q), 32'd0);
        bus.req_last = 4'b0100;
        step();
        check_grant("p37.g2", 2'd2, 4'b0100);
        step();
        bus.req_valid = 4'b0000;
        bus.req_last  = 4'b0000;

`ifdef ARB_TIMEOUT_EN
        // ---- watchdog: grant 3, requester 3 silent for 4 cycles ----
        do_reset();
        bus.req_valid = 4'b1000;
        step();
        check_grant("p38.g3", 2'd3, 4'b1000);
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("p38.wait.busy",  32'(bus.busy),      32'd1);
            check("p38.wait.pulse", 32'(timeout_pulse), 32'd0);
            step();
        end
        check("p38.pulse", 32'(timeout_pulse), 32'd1);
        check_idle("p38.idle", 2'd3);
        step();
        check("p38.pulse.off", 32'(timeout_pulse), 32'd0);
        check_grant("p38.g0", 2'd0, 4'b0001);
        bus.req_valid = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
